// File: rtl/memory_access_if.sv
// Execute->Memory stage bus: Execute results in, MEM/WB results out.
interface memory_access_if;
  logic        ivalid;
  logic        iSig_MemRead;
  logic        iSig_MemWrite;
  logic        iSig_Branch;
  logic        iSig_RegWrite;
  logic        iSig_MemtoReg;
  logic [31:0] iadder_branch_result;
  logic        iALU_zero;
  logic [31:0] iALU_result;
  logic [31:0] iregfile_read_2;
  logic [4:0]  ireg_write_reg;
  logic        ostall;
  logic        ovalid;
  logic        oPCSrc;
  logic [31:0] obranch_target;
  logic        oSig_RegWrite;
  logic        oSig_MemtoReg;
  logic [31:0] omem_read_data;
  logic [31:0] oALU_result;
  logic [4:0]  oreg_write_reg;
  logic        omisaligned;

  modport master (
    output ivalid, iSig_MemRead, iSig_MemWrite, iSig_Branch, iSig_RegWrite, iSig_MemtoReg,
           iadder_branch_result, iALU_zero, iALU_result, iregfile_read_2, ireg_write_reg,
    input  ostall, ovalid, oPCSrc, obranch_target, oSig_RegWrite, oSig_MemtoReg,
           omem_read_data, oALU_result, oreg_write_reg, omisaligned
  );

  modport slave (
    input  ivalid, iSig_MemRead, iSig_MemWrite, iSig_Branch, iSig_RegWrite, iSig_MemtoReg,
           iadder_branch_result, iALU_zero, iALU_result, iregfile_read_2, ireg_write_reg,
    output ostall, ovalid, oPCSrc, obranch_target, oSig_RegWrite, oSig_MemtoReg,
           omem_read_data, oALU_result, oreg_write_reg, omisaligned
  );
endinterface

// File: rtl/memory_access.sv
// Pipeline memory stage: 64x32 data memory, 1-cycle non-loads, 2-cycle loads (stalls upstream).
// Optional MEM_ALIGN_CHECK_EN: misaligned loads/stores fault in one cycle without touching memory.
module memory_access (
  input logic             clk,
  input logic             rst,
  memory_access_if.slave  bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0]  state;
  logic [31:0] mem [0:63];

  logic [5:0]  lat_idx;
  logic [31:0] lat_alu;
  logic [4:0]  lat_dst;
  logic        lat_regwrite;
  logic        lat_memtoreg;
  logic        lat_pcsrc;

  logic accept;
  logic misaligned;
  logic is_store;
  logic is_load;

  always_comb begin
    misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (bus.iSig_MemRead | bus.iSig_MemWrite) & (|bus.iALU_result[1:0]);
`endif
    accept   = bus.ivalid & (state == IDLE) & ~rst;
    // Read+write together behaves as a store only.
    is_store = accept & bus.iSig_MemWrite & ~misaligned;
    is_load  = accept & bus.iSig_MemRead & ~bus.iSig_MemWrite & ~misaligned;
  end

  assign bus.ostall = (state == RD_WAIT);

  // Memory is deliberately left out of reset; accept already excludes rst.
  always_ff @(posedge clk) begin
    if (is_store)
      mem[bus.iALU_result[7:2]] <= bus.iregfile_read_2;
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= accept & misaligned;
  end
  assign bus.omisaligned = mis_q;
`else
  assign bus.omisaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bus.ovalid         <= 1'b0;
      bus.oPCSrc         <= 1'b0;
      bus.obranch_target <= '0;
      bus.oSig_RegWrite  <= 1'b0;
      bus.oSig_MemtoReg  <= 1'b0;
      bus.omem_read_data <= '0;
      bus.oALU_result    <= '0;
      bus.oreg_write_reg <= '0;
      lat_idx            <= '0;
      lat_alu            <= '0;
      lat_dst            <= '0;
      lat_regwrite       <= 1'b0;
      lat_memtoreg       <= 1'b0;
      lat_pcsrc          <= 1'b0;
    end else begin
      bus.ovalid <= 1'b0;
      bus.oPCSrc <= 1'b0;
      if (state == RD_WAIT) begin
        bus.omem_read_data <= mem[lat_idx];
        bus.oALU_result    <= lat_alu;
        bus.oreg_write_reg <= lat_dst;
        bus.oSig_RegWrite  <= lat_regwrite;
        bus.oSig_MemtoReg  <= lat_memtoreg;
        bus.oPCSrc         <= lat_pcsrc;
        bus.ovalid         <= 1'b1;
        state              <= IDLE;
      end else if (accept) begin
        bus.obranch_target <= bus.iadder_branch_result;
        if (is_load) begin
          lat_idx      <= bus.iALU_result[7:2];
          lat_alu      <= bus.iALU_result;
          lat_dst      <= bus.ireg_write_reg;
          lat_regwrite <= bus.iSig_RegWrite;
          lat_memtoreg <= bus.iSig_MemtoReg;
          lat_pcsrc    <= bus.iSig_Branch & bus.iALU_zero;
          state        <= RD_WAIT;
        end else begin
          bus.oALU_result    <= bus.iALU_result;
          bus.oreg_write_reg <= bus.ireg_write_reg;
          bus.oSig_RegWrite  <= bus.iSig_RegWrite & ~misaligned;
          bus.oSig_MemtoReg  <= bus.iSig_MemtoReg;
          bus.oPCSrc         <= bus.iSig_Branch & bus.iALU_zero;
          bus.ovalid         <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: hand-computed vectors checked with immediate assertions.
module tb_memory_access;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  memory_access_if bus();

  memory_access dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic br, input logic zero,
                       input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] wdata, input logic [31:0] tgt, input logic [4:0] dst);
    bus.ivalid               = 1'b1;
    bus.iSig_MemRead         = rd;
    bus.iSig_MemWrite        = wr;
    bus.iSig_Branch          = br;
    bus.iALU_zero            = zero;
    bus.iSig_RegWrite        = rw;
    bus.iSig_MemtoReg        = m2r;
    bus.iALU_result          = alu;
    bus.iregfile_read_2      = wdata;
    bus.iadder_branch_result = tgt;
    bus.ireg_write_reg       = dst;
  endtask

  task automatic idle();
    bus.ivalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    idle();
    tick();
    tick();
    chk("rst_ostall", {31'b0, bus.ostall}, 32'h0);
    chk("rst_ovalid", {31'b0, bus.ovalid}, 32'h0);
    chk("rst_pcsrc", {31'b0, bus.oPCSrc}, 32'h0);
    chk("rst_target", bus.obranch_target, 32'h0);
    chk("rst_rdata", bus.omem_read_data, 32'h0);
    chk("rst_alu", bus.oALU_result, 32'h0);
    chk("rst_dst", {27'b0, bus.oreg_write_reg}, 32'h0);
    chk("rst_mis", {31'b0, bus.omisaligned}, 32'h0);
    rst = 1'b0;

    // ALU-only op
    issue(0, 0, 0, 0, 1, 0, 32'h0000002A, 32'h0, 32'h0, 5'd5);
    tick();
    chk("alu_ovalid", {31'b0, bus.ovalid}, 32'h1);
    chk("alu_result", bus.oALU_result, 32'h2A);
    chk("alu_dst", {27'b0, bus.oreg_write_reg}, 32'd5);
    chk("alu_rw", {31'b0, bus.oSig_RegWrite}, 32'h1);
    chk("alu_ostall", {31'b0, bus.ostall}, 32'h0);
    idle();
    tick();
    chk("alu_pulse_end", {31'b0, bus.ovalid}, 32'h0);
    chk("alu_hold", bus.oALU_result, 32'h2A);

    // store then load, with different inputs presented during the stall
    issue(0, 1, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0);
    tick();
    chk("st_ovalid", {31'b0, bus.ovalid}, 32'h1);
    chk("st_rdata_hold", bus.omem_read_data, 32'h0);
    issue(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd7);
    tick();
    chk("ld_ostall", {31'b0, bus.ostall}, 32'h1);
    chk("ld_wait_ovalid", {31'b0, bus.ovalid}, 32'h0);
    issue(0, 1, 0, 0, 0, 0, 32'h10, 32'h11111111, 32'h0, 5'd9);
    tick();
    idle();
    chk("ld_ovalid", {31'b0, bus.ovalid}, 32'h1);
    chk("ld_rdata", bus.omem_read_data, 32'hDEADBEEF);
    chk("ld_dst", {27'b0, bus.oreg_write_reg}, 32'd7);
    chk("ld_m2r", {31'b0, bus.oSig_MemtoReg}, 32'h1);
    chk("ld_ostall_clr", {31'b0, bus.ostall}, 32'h0);
    issue(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd7);
    tick();
    idle();
    tick();
    chk("stall_ignored", bus.omem_read_data, 32'hDEADBEEF);

    // branches
    issue(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 32'h00400040, 5'd0);
    tick();
    chk("br_taken", {31'b0, bus.oPCSrc}, 32'h1);
    chk("br_target", bus.obranch_target, 32'h00400040);
    idle();
    tick();
    chk("br_pulse_end", {31'b0, bus.oPCSrc}, 32'h0);
    chk("br_target_hold", bus.obranch_target, 32'h00400040);
    issue(0, 0, 1, 0, 0, 0, 32'h4, 32'h0, 32'h00000100, 5'd0);
    tick();
    chk("br_not_taken", {31'b0, bus.oPCSrc}, 32'h0);
    chk("br_target2", bus.obranch_target, 32'h00000100);

    // address wrap
    issue(0, 1, 0, 0, 0, 0, 32'h04, 32'h12345678, 32'h0, 5'd0);
    tick();
    issue(1, 0, 0, 0, 1, 1, 32'h104, 32'h0, 32'h0, 5'd3);
    tick();
    chk("wrap_stall", {31'b0, bus.ostall}, 32'h1);
    idle();
    tick();
    chk("wrap_rdata", bus.omem_read_data, 32'h12345678);
    chk("wrap_alu", bus.oALU_result, 32'h104);

    // read+write together is a store only
    issue(1, 1, 0, 0, 0, 0, 32'h20, 32'hCAFEF00D, 32'h0, 5'd0);
    tick();
    chk("rw_ostall", {31'b0, bus.ostall}, 32'h0);
    chk("rw_ovalid", {31'b0, bus.ovalid}, 32'h1);
    chk("rw_rdata_hold", bus.omem_read_data, 32'h12345678);
    issue(1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd4);
    tick();
    idle();
    tick();
    chk("rw_load", bus.omem_read_data, 32'hCAFEF00D);

    // store coincident with reset is dropped
    issue(0, 1, 0, 0, 0, 0, 32'h20, 32'h00000BAD, 32'h0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_st_ovalid", {31'b0, bus.ovalid}, 32'h0);
    chk("rst_st_rdata", bus.omem_read_data, 32'h0);
    issue(1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd4);
    tick();
    idle();
    tick();
    chk("rst_st_dropped", bus.omem_read_data, 32'hCAFEF00D);

    // reset during RD_WAIT aborts the load
    issue(1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd6);
    tick();
    chk("abort_stall", {31'b0, bus.ostall}, 32'h1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ostall", {31'b0, bus.ostall}, 32'h0);
    chk("abort_ovalid", {31'b0, bus.ovalid}, 32'h0);
    chk("abort_rdata", bus.omem_read_data, 32'h0);
    chk("abort_dst", {27'b0, bus.oreg_write_reg}, 32'h0);
    tick();
    chk("abort_no_late", {31'b0, bus.ovalid}, 32'h0);

    // misaligned store to 0x12
    issue(0, 1, 0, 0, 1, 0, 32'h12, 32'h00000055, 32'h0, 5'd2);
    tick();
    chk("mis_ovalid", {31'b0, bus.ovalid}, 32'h1);
    chk("mis_ostall", {31'b0, bus.ostall}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, bus.omisaligned}, 32'h1);
    chk("mis_rw", {31'b0, bus.oSig_RegWrite}, 32'h0);
    issue(1, 0, 0, 0, 1, 1, 32'h13, 32'h0, 32'h0, 5'd2);
    tick();
    chk("mis_ld_stall", {31'b0, bus.ostall}, 32'h0);
    chk("mis_ld_flag", {31'b0, bus.omisaligned}, 32'h1);
    issue(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd2);
    tick();
    idle();
    tick();
    chk("mis_prior", bus.omem_read_data, 32'hDEADBEEF);
    chk("mis_clear", {31'b0, bus.omisaligned}, 32'h0);
`else
    chk("mis_flag", {31'b0, bus.omisaligned}, 32'h0);
    chk("mis_rw", {31'b0, bus.oSig_RegWrite}, 32'h1);
    issue(1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd2);
    tick();
    idle();
    tick();
    chk("mis_ignored_bits", bus.omem_read_data, 32'h00000055);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
